// File: rtl/module_errordisp_pkg.sv
// Shared types and segment constants for the error counter display.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high here;
// polarity is applied only at the top-level output registers.
package module_errordisp_pkg;

  typedef logic [6:0] seg7;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam seg7 SEG_E     = 7'h79;
  localparam seg7 SEG_DASH  = 7'h40;
  localparam seg7 SEG_BLANK = 7'h00;

  // Hex digit glyphs 0..F
  localparam seg7 HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/module_hex7seg.sv
// Combinational 4-bit to 7-segment decoder, active-high segments.
module module_hex7seg
  import module_errordisp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7        seg
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/module_errordisp_scan.sv
// Saturating bit-error counter shown on a multiplexed 7-segment display.
// Lower digits show the count in hex, the top digit shows 'E' (blinking)
// once an error has been seen, or '-' otherwise.
module module_errordisp_scan
  import module_errordisp_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int BLINK_DIV      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_error,
  input  logic                clr_error,
  output logic [6:0]          disp_error,
  output logic [N_DIGITS-1:0] disp_an,
  output logic                error_flag
);

  localparam int CNT_W = 4 * (N_DIGITS - 1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0]          SEG_POL  = {7{SEG_ACTIVE_LOW}};

  logic                edge_r;
  logic [CNT_W-1:0]    err_cnt_r;
  logic                error_flag_r;
  logic                rise_s;

  scan_state_e         state_r;
  logic [PRE_W-1:0]    presc_r;
  logic [IDX_W-1:0]    idx_r;
  logic                wrap_s;

  logic [BLK_W-1:0]    blink_cnt_r;
  logic                blink_on_r;

  logic [3:0]          nibble_s;
  seg7                 hex_seg_s;
  seg7                 seg_sel_s;
  logic [N_DIGITS-1:0] an_sel_s;

  logic [6:0]          disp_error_r;
  logic [N_DIGITS-1:0] disp_an_r;

  assign rise_s = bit_error & ~edge_r;
  assign wrap_s = (presc_r == PRE_LAST);

  // Edge detect, saturating error counter and sticky flag; clear beats a same-cycle edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_r       <= 1'b0;
      err_cnt_r    <= {CNT_W{1'b0}};
      error_flag_r <= 1'b0;
    end else begin
      edge_r <= bit_error;
      if (clr_error) begin
        err_cnt_r    <= {CNT_W{1'b0}};
        error_flag_r <= 1'b0;
      end else if (rise_s) begin
        if (err_cnt_r != CNT_MAX) begin
          err_cnt_r <= err_cnt_r + CNT_W'(1);
        end else begin
          err_cnt_r <= err_cnt_r;
        end
        error_flag_r <= 1'b1;
      end else begin
        err_cnt_r    <= err_cnt_r;
        error_flag_r <= error_flag_r;
      end
    end
  end

  // Scan FSM with prescaler and digit index: one blank cycle then show until wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      presc_r <= {PRE_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      if (wrap_s) begin
        presc_r <= {PRE_W{1'b0}};
        idx_r   <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end else begin
        presc_r <= presc_r + PRE_W'(1);
        idx_r   <= idx_r;
      end
      case (state_r)
        ST_BLANK: state_r <= ST_SHOW;
        ST_SHOW:  state_r <= wrap_s ? ST_BLANK : ST_SHOW;
        default:  state_r <= ST_BLANK;
      endcase
    end
  end

  // Blink phase: toggles every BLINK_DIV full scan rounds while the flag is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_on_r  <= 1'b1;
    end else if (!error_flag_r) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_on_r  <= 1'b1;
    end else if (wrap_s && (idx_r == IDX_LAST)) begin
      if (blink_cnt_r == BLK_LAST) begin
        blink_cnt_r <= {BLK_W{1'b0}};
        blink_on_r  <= ~blink_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLK_W'(1);
        blink_on_r  <= blink_on_r;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_on_r  <= blink_on_r;
    end
  end

  // Pick the counter nibble belonging to the current digit
  always_comb begin
    nibble_s = 4'h0;
    for (int i = 0; i < N_DIGITS - 1; i++) begin
      nibble_s = (idx_r == IDX_W'(i)) ? err_cnt_r[4*i +: 4] : nibble_s;
    end
  end

  module_hex7seg u_hex7seg (
    .nibble (nibble_s),
    .seg    (hex_seg_s)
  );

  // Active-high anode and segment selection for the current slot
  always_comb begin
    seg_sel_s = SEG_BLANK;
    an_sel_s  = {N_DIGITS{1'b0}};
    if (state_r == ST_SHOW) begin
      an_sel_s = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_r;
      if (idx_r == IDX_LAST) begin
        if (error_flag_r) begin
          seg_sel_s = blink_on_r ? SEG_E : SEG_BLANK;
        end else begin
          seg_sel_s = SEG_DASH;
        end
      end else begin
        seg_sel_s = hex_seg_s;
      end
    end else begin
      seg_sel_s = SEG_BLANK;
      an_sel_s  = {N_DIGITS{1'b0}};
    end
  end

  // Output registers; polarity is applied only here, reset drives everything off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_an_r    <= AN_POL;
      disp_error_r <= SEG_POL;
    end else begin
      disp_an_r    <= an_sel_s ^ AN_POL;
      disp_error_r <= seg_sel_s ^ SEG_POL;
    end
  end

  assign disp_an    = disp_an_r;
  assign disp_error = disp_error_r;
  assign error_flag = error_flag_r;

endmodule

// File: tb/tb_module_errordisp_scan.sv
// Self-checking bench for module_errordisp_scan (3 digits, 4-cycle slots, blink every 2 rounds).
module tb_module_errordisp_scan;

  localparam int ND = 3;
  localparam int SD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_error = 1'b0;
  logic       clr_error = 1'b0;
  logic [6:0] disp_error;
  logic [2:0] disp_an;
  logic       error_flag;

  int checks = 0;
  int failures = 0;

  // reference model state
  int   m_cnt;
  int   m_k;
  int   m_rounds;
  bit   m_flag;
  bit   m_prev;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  module_errordisp_scan #(
    .N_DIGITS       (ND),
    .SCAN_DIV       (SD),
    .BLINK_DIV      (BD),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_error  (bit_error),
    .clr_error  (clr_error),
    .disp_error (disp_error),
    .disp_an    (disp_an),
    .error_flag (error_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_k = 0; m_rounds = 0; m_flag = 1'b0; m_prev = 1'b0;
  endtask

  // One clock edge of the reference: display from the pre-edge state, then update
  task automatic model_edge(input bit b, input bit c);
    int t;
    int d;
    logic [6:0] s;
    t = m_k;
    if (t % SD == 0) begin
      exp_an  = 3'b111;
      exp_seg = 7'h7F;
    end else begin
      d = (t / SD) % ND;
      exp_an = ~(3'b001 << d);
      if (d < ND - 1) s = hex_tab[(m_cnt >> (4 * d)) & 15];
      else if (m_flag) s = (((m_rounds / BD) % 2) == 0) ? 7'h79 : 7'h00;
      else s = 7'h40;
      exp_seg = ~s;
    end
    if (!m_flag) m_rounds = 0;
    else if (t % (SD * ND) == SD * ND - 1) m_rounds++;
    if (c) begin
      m_cnt = 0; m_flag = 1'b0;
    end else if (b && !m_prev) begin
      if (m_cnt < 255) m_cnt++;
      m_flag = 1'b1;
    end
    m_prev = b;
    m_k++;
  endtask

  // Drive inputs for one cycle and compare everything on the falling edge
  task automatic cyc(input bit b, input bit c);
    bit_error = b;
    clr_error = c;
    @(posedge clk);
    model_edge(b, c);
    @(negedge clk);
    chk("disp_an", disp_an, exp_an);
    chk("disp_error", disp_error, exp_seg);
    chk("error_flag", error_flag, m_flag);
    chk("err_cnt", dut.err_cnt_r, m_cnt);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0; bit_error = 1'b0; clr_error = 1'b0;
    repeat (hold) @(negedge clk);
    chk("rst_an", disp_an, 3'b111);
    chk("rst_seg", disp_error, 7'h7F);
    chk("rst_flag", error_flag, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    model_reset();

    // reset and plain scan order
    do_reset(5);
    repeat (2 * SD * ND) cyc(1'b0, 1'b0);

    // three 2-cycle pulses, then a held level counting once
    repeat (3) begin
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    end
    chk("cnt_three", dut.err_cnt_r, 8'h03);
    chk("flag_set", error_flag, 1'b1);
    repeat (SD * ND) cyc(1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b0);
    chk("cnt_held_once", dut.err_cnt_r, 8'h04);
    cyc(1'b0, 1'b0);

    // saturation
    repeat (260) begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
    chk("cnt_sat", dut.err_cnt_r, 8'hFF);
    repeat (5) begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
    chk("cnt_sat_hold", dut.err_cnt_r, 8'hFF);
    repeat (SD * ND) cyc(1'b0, 1'b0);

    // clear racing a rising edge at count 5
    cyc(1'b0, 1'b1);
    repeat (5) begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
    chk("cnt_five", dut.err_cnt_r, 8'h05);
    cyc(1'b1, 1'b1);
    chk("race_cnt", dut.err_cnt_r, 8'h00);
    chk("race_flag", error_flag, 1'b0);
    repeat (SD * ND) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    // error present at reset release counts once, then blink over several rounds
    do_reset(3);
    cyc(1'b1, 1'b0);
    chk("release_count", dut.err_cnt_r, 8'h01);
    repeat (6 * SD * ND) cyc(1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    // asynchronous reset in the middle of digit 1's slot
    found = 1'b0;
    for (int i = 0; i < 2 * SD * ND && !found; i++) begin
      cyc(1'b0, 1'b0);
      if (disp_an === 3'b101) found = 1'b1;
    end
    chk("find_show1", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", disp_an, 3'b111);
    chk("async_seg", disp_error, 7'h7F);
    chk("async_flag", error_flag, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (SD * ND) cyc(1'b0, 1'b0);
    chk("post_reset_cnt", dut.err_cnt_r, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
